l2_set_rd_ctrl: RTL and testbench
=================================

L2_SET_RD_CTRL -- requirements
Module: l2_set_rd_ctrl

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters; index 0 = rsp, 1 = fwd, 2 = cpu req.
REQ-002 Parameter SET_BITS, default 8: width of L2 set index.
REQ-003 Parameter RD_LAT, default 1, legal 1..7: cycles from localmem read enable until localmem read data is valid.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  N_REQ  per-requester set-read request.
REQ-007 req_set  in  N_REQ*SET_BITS  per-requester set index; slice i = bits [i*SET_BITS +: SET_BITS].
REQ-008 req_ready  out  N_REQ  one-hot accept; a request is accepted in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-009 lmem_rd_en  out  1  localmem set-read enable pulse.
REQ-010 lmem_rd_set  out  SET_BITS  set index presented with lmem_rd_en.
REQ-011 rd_set_into_bufs  out  1  load pulse to the L2 set buffers.
REQ-012 bufs_valid  out  1  set buffers hold the granted set.
REQ-013 bufs_owner  out  N_REQ  one-hot owner of the buffers; 0 when bufs_valid = 0.
REQ-014 bufs_set  out  SET_BITS  set index currently loaded or being loaded.
REQ-015 release  in  1  owner is done with the buffers.

Function
REQ-016 The FSM SHALL have four states: IDLE, WAIT, LOAD and HOLD.
REQ-017 In IDLE with any req_valid, the controller SHALL grant the lowest set index i with req_valid[i] (fixed priority).
- Same cycle: req_ready = one-hot(i), lmem_rd_en = 1, lmem_rd_set = req_set slice i.
- Next cycle: bufs_set and owner register <= i / set, latency counter <= RD_LAT-1, state <= WAIT (RD_LAT > 1) or LOAD (RD_LAT = 1).
REQ-018 req_ready SHALL be 0 in every state except IDLE; lmem_rd_en SHALL be 1 only in a granting IDLE cycle.
REQ-019 In WAIT, the counter SHALL decrement each cycle; state SHALL move to LOAD in the cycle after the counter reaches 1.
REQ-020 rd_set_into_bufs SHALL be 1 for exactly one cycle, in LOAD, exactly RD_LAT cycles after the lmem_rd_en cycle; state <= HOLD.
REQ-021 In HOLD, bufs_valid SHALL be 1 and bufs_owner SHALL equal the registered one-hot grant.
REQ-022 release in HOLD SHALL move state to IDLE next cycle; bufs_valid SHALL be 0 from that cycle.
- No grant in the release cycle itself; earliest new grant is the following cycle.
REQ-023 release outside HOLD SHALL be ignored.
REQ-024 Changes to req_valid/req_set after acceptance SHALL NOT affect bufs_set or the owner.
REQ-025 A non-granted requester SHALL keep waiting; there is no timeout; starvation of lower priorities is accepted.
REQ-026 Outputs lmem_rd_en, req_ready, rd_set_into_bufs, bufs_valid and bufs_owner SHALL be mutually consistent every cycle: at most one of lmem_rd_en, rd_set_into_bufs, bufs_valid is 1.

Reset
REQ-027 On rst = 0 the block SHALL immediately set: state IDLE, counter 0, owner 0, bufs_set 0.
- All outputs 0 while rst = 0, including req_ready.
REQ-028 Reset asserted in WAIT, LOAD or HOLD SHALL abort the operation with no rd_set_into_bufs pulse afterwards.
REQ-029 The first grant SHALL be possible in the first clock edge after rst deasserts with req_valid high.

Verification
REQ-030 Single request: RD_LAT=1, req_valid=3'b100 with set 8'h2A at cycle T.
- Response: req_ready=3'b100 and lmem_rd_en=1 with set 2A at T; rd_set_into_bufs at T+1; bufs_valid=1, bufs_owner=3'b100, bufs_set=2A from T+2 until release.
REQ-031 Priority: req_valid=3'b111 with sets 01/02/03 -> grant 3'b001 with set 01; after release, next grant 3'b010 with set 02.
REQ-032 Latency: RD_LAT=3, grant at T -> rd_set_into_bufs only at T+3; no lmem_rd_en at T+1..T+3.
REQ-033 Release timing: release at H -> bufs_valid=0 at H+1; with pending req_valid=3'b010, the next grant is at H+1, never at H.
REQ-034 Reset mid-op: rst low in WAIT (RD_LAT=3) -> all outputs 0 at once, no load pulse; after rst high, a new request is granted on the next edge.
REQ-035 Stray release: release=1 in IDLE and in WAIT -> no state change; the load pulse still occurs at the correct cycle.

Source files
------------

// File: rtl/l2_set_rd_ctrl_if.sv
// Bus bundle between the L2 set-read controller, its requesters, the
// localmem read port and the L2 set buffers.
// The buffer release strobe is named bufs_release because "release" is a
// reserved word in SystemVerilog.
interface l2_set_rd_ctrl_if #(
    parameter int N_REQ    = 3,
    parameter int SET_BITS = 8
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*SET_BITS-1:0] req_set;
    logic [N_REQ-1:0]          req_ready;
    logic                      lmem_rd_en;
    logic [SET_BITS-1:0]       lmem_rd_set;
    logic                      rd_set_into_bufs;
    logic                      bufs_valid;
    logic [N_REQ-1:0]          bufs_owner;
    logic [SET_BITS-1:0]       bufs_set;
    logic                      bufs_release;

    // Requester / environment side.
    modport master (
        output req_valid, req_set, bufs_release,
        input  req_ready, lmem_rd_en, lmem_rd_set, rd_set_into_bufs,
               bufs_valid, bufs_owner, bufs_set
    );

    // Controller side.
    modport slave (
        input  req_valid, req_set, bufs_release,
        output req_ready, lmem_rd_en, lmem_rd_set, rd_set_into_bufs,
               bufs_valid, bufs_owner, bufs_set
    );
endinterface

// File: rtl/l2_set_rd_ctrl.sv
// L2 set-read controller: fixed-priority arbitration between requesters for
// the single set of L2 set buffers, issue of the localmem set read, load
// strobe after RD_LAT cycles, then hold until the owner releases.
module l2_set_rd_ctrl #(
    parameter int N_REQ    = 3,
    parameter int SET_BITS = 8,
    parameter int RD_LAT   = 1
) (
    input logic               clk,
    input logic               rst,
    l2_set_rd_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, WAIT, LOAD, HOLD} state_t;

    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t              state_reg, state_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic [N_REQ-1:0]    owner_reg, owner_next;
    logic [SET_BITS-1:0] bset_reg, bset_next;

    logic [N_REQ:0]      seen;
    logic [N_REQ-1:0]    grant_oh;
    logic [SET_BITS-1:0] grant_set;

    logic [N_REQ-1:0]    ready;
    logic                rd_en;
    logic                load;
    logic                bv;
    logic [N_REQ-1:0]    owner_out;

    // Fixed priority: a requester wins only if no lower index is requesting.
    assign seen[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_prio
            assign grant_oh[gi]   = bus.req_valid[gi] & ~seen[gi];
            assign seen[gi+1]     = seen[gi] | bus.req_valid[gi];
        end
    endgenerate

    // Mux the winning requester's set index (grant_oh is one-hot or zero).
    always_comb begin
        grant_set = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                grant_set = grant_set | bus.req_set[i*SET_BITS +: SET_BITS];
            end
        end
    end

    // Next-state and output decode; rst gates the combinational grant so
    // nothing leaks out while reset is held.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        bset_next  = bset_reg;
        ready      = '0;
        rd_en      = 1'b0;
        load       = 1'b0;
        bv         = 1'b0;
        owner_out  = '0;
        case (state_reg)
            IDLE: begin
                if (rst && seen[N_REQ]) begin
                    ready      = grant_oh;
                    rd_en      = 1'b1;
                    owner_next = grant_oh;
                    bset_next  = grant_set;
                    cnt_next   = LAT_M1;
                    state_next = (RD_LAT > 1) ? WAIT : LOAD;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg <= 3'd1) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                bv        = 1'b1;
                owner_out = owner_reg;
                if (bus.bufs_release) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latency counter and grant capture; reset aborts any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            owner_reg <= '0;
            bset_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
            bset_reg  <= bset_next;
        end
    end

    assign bus.req_ready        = ready;
    assign bus.lmem_rd_en       = rd_en;
    assign bus.lmem_rd_set      = rd_en ? grant_set : '0;
    assign bus.rd_set_into_bufs = load;
    assign bus.bufs_valid       = bv;
    assign bus.bufs_owner       = owner_out;
    assign bus.bufs_set         = bset_reg;

endmodule

// File: tb/tb_l2_set_rd_ctrl.sv
// Testbench for l2_set_rd_ctrl: a vector table on an RD_LAT=1 instance, a
// hand-written sequence on an RD_LAT=3 instance, then random traffic on
// both against a cycle-count based reference model.
module tb_l2_set_rd_ctrl;

    logic clk = 1'b0;
    logic rst1 = 1'b0;
    logic rst3 = 1'b0;
    always #5 clk = ~clk;

    l2_set_rd_ctrl_if #(.N_REQ(3), .SET_BITS(8)) bus1 ();
    l2_set_rd_ctrl_if #(.N_REQ(3), .SET_BITS(8)) bus3 ();

    l2_set_rd_ctrl #(.N_REQ(3), .SET_BITS(8), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    l2_set_rd_ctrl #(.N_REQ(3), .SET_BITS(8), .RD_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        r;
        logic [2:0]  v;
        logic [23:0] s;
        logic        rel;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl [18];

    // Reference model state per instance (0: RD_LAT=1, 1: RD_LAT=3).
    bit         m_busy [2];
    int         m_age  [2];
    logic [2:0] m_own  [2];
    logic [7:0] m_bset [2];

    function automatic logic [24:0] pk(input logic [2:0] rdy, input logic en,
                                       input logic [7:0] rs, input logic ld,
                                       input logic bv, input logic [2:0] own,
                                       input logic [7:0] bs);
        return {rdy, en, rs, ld, bv, own, bs};
    endfunction

    function automatic logic [24:0] act(input int k);
        if (k == 0)
            return {bus1.req_ready, bus1.lmem_rd_en, bus1.lmem_rd_set,
                    bus1.rd_set_into_bufs, bus1.bufs_valid, bus1.bufs_owner,
                    bus1.bufs_set};
        else
            return {bus3.req_ready, bus3.lmem_rd_en, bus3.lmem_rd_set,
                    bus3.rd_set_into_bufs, bus3.bufs_valid, bus3.bufs_owner,
                    bus3.bufs_set};
    endfunction

    task automatic set_in(input int k, input logic r, input logic [2:0] v,
                          input logic [23:0] s, input logic rel);
        if (k == 0) begin
            rst1 = r; bus1.req_valid = v; bus1.req_set = s; bus1.bufs_release = rel;
        end else begin
            rst3 = r; bus3.req_valid = v; bus3.req_set = s; bus3.bufs_release = rel;
        end
    endtask

    task automatic check(input string name, input int idx,
                         input logic [24:0] got, input logic [24:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s #%0d: got %h want %h", name, idx, got, want);
        end else begin
            $display("ok   %s #%0d: %h", name, idx, got);
        end
    endtask

    // One cycle of the RD_LAT=3 instance: drive, settle, compare.
    task automatic step3(input int idx, input logic r, input logic [2:0] v,
                         input logic [23:0] s, input logic rel,
                         input logic [24:0] want);
        @(negedge clk);
        set_in(1, r, v, s, rel);
        #1;
        check("lat3_seq", idx, act(1), want);
    endtask

    // Behavioural reference: tracks how many cycles have passed since the
    // grant. The load strobe lands exactly lat cycles after the grant, the
    // buffers are valid afterwards until the cycle following a release.
    task automatic model(input int k, input int lat, input logic r,
                         input logic [2:0] v, input logic [23:0] s,
                         input logic rel, output logic [24:0] e);
        int win;
        e = '0;
        if (!r) begin
            m_busy[k] = 0;
            m_bset[k] = 8'h00;
            return;
        end
        if (!m_busy[k]) begin
            win = -1;
            for (int i = 2; i >= 0; i--) if (v[i]) win = i;
            if (win >= 0) begin
                e = pk(3'(1 << win), 1'b1, s[win*8 +: 8], 1'b0, 1'b0, 3'b000, m_bset[k]);
                m_busy[k] = 1;
                m_age[k]  = 0;
                m_own[k]  = 3'(1 << win);
                m_bset[k] = s[win*8 +: 8];
            end else begin
                e = pk(3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, m_bset[k]);
            end
        end else begin
            m_age[k]++;
            if (m_age[k] == lat) begin
                e = pk(3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 3'b000, m_bset[k]);
            end else if (m_age[k] > lat) begin
                e = pk(3'b000, 1'b0, 8'h00, 1'b0, 1'b1, m_own[k], m_bset[k]);
                if (rel) m_busy[k] = 0;
            end else begin
                e = pk(3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, m_bset[k]);
            end
        end
    endtask

    localparam logic [23:0] S = 24'h030201;

    initial begin
        logic [24:0] e;
        logic        rr [2];
        logic [2:0]  vv [2];
        logic [23:0] ss [2];
        logic        ll [2];

        set_in(0, 1'b0, 3'b000, 24'h0, 1'b0);
        set_in(1, 1'b0, 3'b000, 24'h0, 1'b0);

        // RD_LAT=1: single request, release timing, priority, reset in HOLD.
        tbl[0]  = {1'b0, 3'b100, 24'h2A0000, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h00)};
        tbl[1]  = {1'b1, 3'b100, 24'h2A0000, 1'b0, pk(3'b100, 1, 8'h2A, 0, 0, 3'b000, 8'h00)};
        tbl[2]  = {1'b1, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 1, 0, 3'b000, 8'h2A)};
        tbl[3]  = {1'b1, 3'b011, S,          1'b0, pk(3'b000, 0, 8'h00, 0, 1, 3'b100, 8'h2A)};
        tbl[4]  = {1'b1, 3'b010, S,          1'b1, pk(3'b000, 0, 8'h00, 0, 1, 3'b100, 8'h2A)};
        tbl[5]  = {1'b1, 3'b010, S,          1'b0, pk(3'b010, 1, 8'h02, 0, 0, 3'b000, 8'h2A)};
        tbl[6]  = {1'b1, 3'b111, S,          1'b1, pk(3'b000, 0, 8'h00, 1, 0, 3'b000, 8'h02)};
        tbl[7]  = {1'b1, 3'b111, S,          1'b0, pk(3'b000, 0, 8'h00, 0, 1, 3'b010, 8'h02)};
        tbl[8]  = {1'b1, 3'b111, S,          1'b1, pk(3'b000, 0, 8'h00, 0, 1, 3'b010, 8'h02)};
        tbl[9]  = {1'b1, 3'b111, S,          1'b0, pk(3'b001, 1, 8'h01, 0, 0, 3'b000, 8'h02)};
        tbl[10] = {1'b1, 3'b111, S,          1'b0, pk(3'b000, 0, 8'h00, 1, 0, 3'b000, 8'h01)};
        tbl[11] = {1'b1, 3'b111, S,          1'b1, pk(3'b000, 0, 8'h00, 0, 1, 3'b001, 8'h01)};
        tbl[12] = {1'b1, 3'b110, S,          1'b0, pk(3'b010, 1, 8'h02, 0, 0, 3'b000, 8'h01)};
        tbl[13] = {1'b1, 3'b000, S,          1'b0, pk(3'b000, 0, 8'h00, 1, 0, 3'b000, 8'h02)};
        tbl[14] = {1'b1, 3'b000, S,          1'b0, pk(3'b000, 0, 8'h00, 0, 1, 3'b010, 8'h02)};
        tbl[15] = {1'b0, 3'b111, S,          1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h00)};
        tbl[16] = {1'b1, 3'b000, S,          1'b1, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h00)};
        tbl[17] = {1'b1, 3'b001, S,          1'b0, pk(3'b001, 1, 8'h01, 0, 0, 3'b000, 8'h00)};

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            set_in(0, tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].rel);
            #1;
            check("lat1_tbl", i, act(0), tbl[i].exp);
        end
        @(negedge clk);
        set_in(0, 1'b0, 3'b000, 24'h0, 1'b0);

        // RD_LAT=3: latency, stray release in WAIT, reset mid-operation.
        step3(0,  1'b0, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h00));
        step3(1,  1'b1, 3'b100, 24'h2A0000, 1'b0, pk(3'b100, 1, 8'h2A, 0, 0, 3'b000, 8'h00));
        step3(2,  1'b1, 3'b000, 24'h000000, 1'b1, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h2A));
        step3(3,  1'b1, 3'b001, 24'h000055, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h2A));
        step3(4,  1'b1, 3'b001, 24'h000055, 1'b0, pk(3'b000, 0, 8'h00, 1, 0, 3'b000, 8'h2A));
        step3(5,  1'b1, 3'b001, 24'h000055, 1'b1, pk(3'b000, 0, 8'h00, 0, 1, 3'b100, 8'h2A));
        step3(6,  1'b1, 3'b001, 24'h000055, 1'b0, pk(3'b001, 1, 8'h55, 0, 0, 3'b000, 8'h2A));
        step3(7,  1'b1, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h55));
        step3(8,  1'b0, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h00));
        step3(9,  1'b1, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h00));
        step3(10, 1'b1, 3'b010, 24'h007700, 1'b0, pk(3'b010, 1, 8'h77, 0, 0, 3'b000, 8'h00));
        step3(11, 1'b1, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h77));
        step3(12, 1'b1, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h77));
        step3(13, 1'b1, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 1, 0, 3'b000, 8'h77));
        step3(14, 1'b1, 3'b000, 24'h000000, 1'b1, pk(3'b000, 0, 8'h00, 0, 1, 3'b010, 8'h77));
        step3(15, 1'b1, 3'b000, 24'h000000, 1'b0, pk(3'b000, 0, 8'h00, 0, 0, 3'b000, 8'h77));

        // Random traffic on both instances against the reference model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rr[k] = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
                vv[k] = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
                ss[k] = 24'($urandom);
                ll[k] = ($urandom_range(0, 2) == 0);
                set_in(k, rr[k], vv[k], ss[k], ll[k]);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                model(k, (k == 0) ? 1 : 3, rr[k], vv[k], ss[k], ll[k], e);
                check((k == 0) ? "rand_lat1" : "rand_lat3", c, act(k), e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
